// File: rtl/tm1638_pkg.sv
// TM1638 serial-link constants, states and command helpers.
// Shared by the host driver and the device-side responder.
package tm1638_pkg;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_CTRL = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    localparam int READ_BIT  = 1;
    localparam int FIXED_BIT = 2;

    localparam int KEY_BYTES = 4;
    localparam int RAM_BYTES = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

    function automatic state_t cmd_next(input logic [7:0] cmd);
        state_t s;
        s = S_IGNORE;
        unique case (cmd[7:6])
            CMD_DATA: s = cmd[READ_BIT] ? S_RDATA : S_IGNORE;
            CMD_ADDR: s = S_WDATA;
            default:  s = S_IGNORE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tm1638_sio_responder_if.sv
// TM1638 three-wire serial link: STB/CLK/DIO with split data direction.
interface tm1638_sio_if;

    logic sclk;
    logic stb;
    logic dio_in;
    logic dio_out;
    logic dio_oe;

    modport master (
        output sclk,
        output stb,
        output dio_in,
        input  dio_out,
        input  dio_oe
    );

    modport slave (
        input  sclk,
        input  stb,
        input  dio_in,
        output dio_out,
        output dio_oe
    );

endinterface

// File: rtl/tm1638_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized copy.
module tm1638_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/tm1638_sio_responder.sv
// TM1638 device-side responder: decodes host frames into display RAM
// and control, and shifts key-scan bytes back on read frames.
module tm1638_sio_responder
    import tm1638_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    tm1638_sio_if.slave                sio,
    input  logic [8*KEY_BYTES-1:0]     key_in,
    output logic [8*RAM_BYTES-1:0]     disp_ram,
    output logic                       disp_on,
    output logic [2:0]                 brightness,
    output logic                       wr_strobe,
    output logic [3:0]                 wr_addr,
    output logic                       frame_err
);

    logic sclk_q_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic stb_q;
    logic stb_rise;
    logic stb_fall;
    logic dio_q;
    logic dio_rise_unused;
    logic dio_fall_unused;

    tm1638_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sclk (
        .clk  (clk),
        .rst  (rst),
        .d    (sio.sclk),
        .q    (sclk_q_unused),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // Reset low so a strobe already held low after reset is not
    // mistaken for a new frame start.
    tm1638_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_stb (
        .clk  (clk),
        .rst  (rst),
        .d    (sio.stb),
        .q    (stb_q),
        .rise (stb_rise),
        .fall (stb_fall)
    );

    tm1638_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_dio (
        .clk  (clk),
        .rst  (rst),
        .d    (sio.dio_in),
        .q    (dio_q),
        .rise (dio_rise_unused),
        .fall (dio_fall_unused)
    );

    state_t                          state;
    state_t                          state_n;
    logic [2:0]                      bit_cnt;
    logic [7:0]                      shreg;
    logic [7:0]                      rx_byte;
    logic                            sample;
    logic                            byte_done;
    logic [3:0]                      ptr;
    logic                            fixed_mode;
    logic [RAM_BYTES-1:0][7:0]       ram;
    logic [8*KEY_BYTES-1:0]          key_snap;
    logic [5:0]                      rd_idx;
    logic                            dio_out_r;
    logic                            dio_oe_r;

    assign sample    = sclk_rise & ~stb_q & (state != S_IDLE);
    assign rx_byte   = {dio_q, shreg[7:1]};
    assign byte_done = sample & (bit_cnt == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (stb_rise) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (stb_fall) state_n = S_CMD;
                S_CMD:   if (byte_done) state_n = cmd_next(rx_byte);
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            ptr        <= '0;
            fixed_mode <= 1'b0;
            ram        <= '0;
            disp_on    <= 1'b0;
            brightness <= '0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            frame_err  <= 1'b0;
            key_snap   <= '0;
            rd_idx     <= '0;
            dio_out_r  <= 1'b0;
            dio_oe_r   <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (stb_rise) begin
                frame_err <= (bit_cnt != 3'd0);
                bit_cnt   <= '0;
                dio_oe_r  <= 1'b0;
                dio_out_r <= 1'b0;
            end else begin
                if (sample) begin
                    shreg   <= rx_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done && state == S_CMD) begin
                    unique case (rx_byte[7:6])
                        CMD_DATA: begin
                            fixed_mode <= rx_byte[FIXED_BIT];
                            key_snap   <= key_in;
                            rd_idx     <= '0;
                        end
                        CMD_CTRL: begin
                            disp_on    <= rx_byte[3];
                            brightness <= rx_byte[2:0];
                        end
                        CMD_ADDR: ptr <= rx_byte[3:0];
                        default: ;
                    endcase
                end
                if (byte_done && state == S_WDATA) begin
                    ram[ptr]  <= rx_byte;
                    wr_strobe <= 1'b1;
                    wr_addr   <= ptr;
                    if (!fixed_mode) ptr <= ptr + 4'd1;
                end
                // rd_idx[5] marks all key bytes sent; pad with zeros after.
                if (sclk_fall && state == S_RDATA) begin
                    dio_oe_r <= 1'b1;
                    if (!rd_idx[5]) begin
                        dio_out_r <= key_snap[rd_idx[4:0]];
                        rd_idx    <= rd_idx + 6'd1;
                    end else begin
                        dio_out_r <= 1'b0;
                    end
                end
            end
        end
    end

    assign disp_ram    = ram;
    assign sio.dio_out = dio_out_r;
    assign sio.dio_oe  = dio_oe_r;

endmodule

// File: tb/tb_tm1638_sio_responder.sv
// Scoreboard bench for tm1638_sio_responder driven as a TM1638 host.
module tb_tm1638_sio_responder;
    import tm1638_pkg::*;

    localparam int H = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  key_in;
    logic [127:0] disp_ram;
    logic         disp_on;
    logic [2:0]   brightness;
    logic         wr_strobe;
    logic [3:0]   wr_addr;
    logic         frame_err;

    always #5 clk = ~clk;

    tm1638_sio_if sio();

    tm1638_sio_responder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .sio        (sio),
        .key_in     (key_in),
        .disp_ram   (disp_ram),
        .disp_on    (disp_on),
        .brightness (brightness),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .frame_err  (frame_err)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] tx[$];
    logic [7:0] m_ram[16];
    logic [3:0] m_ptr;
    bit         m_fixed;
    bit         m_on;
    logic [2:0] m_br;
    int         ferr_seen = 0;
    int         ferr_exp  = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every RAM write the DUT reports is matched
    // against the oldest write the model predicted.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", {124'd0, wr_addr}, 128'hFFFF);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                check("wr_addr", wr_addr, e.a);
                check("wr_data", disp_ram[8*wr_addr +: 8], e.d);
            end
        end
        if (frame_err === 1'b1) ferr_seen++;
    end

    task automatic m_reset();
        for (int a = 0; a < 16; a++) m_ram[a] = 8'h00;
        m_ptr   = 4'd0;
        m_fixed = 1'b0;
        m_on    = 1'b0;
        m_br    = 3'd0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sio.dio_in = b;
        sio.sclk   = 1'b0;
        wait_clk(H);
        sio.sclk   = 1'b1;
        wait_clk(H);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic check_state(input string tag);
        logic [127:0] exp;
        for (int a = 0; a < 16; a++) exp[8*a +: 8] = m_ram[a];
        check({tag, "_ram"}, disp_ram, exp);
        check({tag, "_on"}, disp_on, m_on);
        check({tag, "_br"}, brightness, m_br);
    endtask

    task automatic do_frame(input logic [7:0] cmd);
        logic [7:0] d;
        case (cmd[7:6])
            2'b01: m_fixed = cmd[2];
            2'b10: begin m_on = cmd[3]; m_br = cmd[2:0]; end
            2'b11: m_ptr = cmd[3:0];
            default: ;
        endcase
        sio.stb = 1'b0;
        wait_clk(H);
        send_byte(cmd);
        while (tx.size() > 0) begin
            d = tx.pop_front();
            if (cmd[7:6] == 2'b11) begin
                exp_wr.push_back({m_ptr, d});
                m_ram[m_ptr] = d;
                if (!m_fixed) m_ptr = m_ptr + 4'd1;
            end
            send_byte(d);
        end
        wait_clk(H);
        sio.stb = 1'b1;
        wait_clk(3*H);
    endtask

    task automatic do_read(input logic [7:0] cmd, input logic [31:0] keys);
        logic [31:0] snap;
        logic [7:0]  got;
        key_in  = keys;
        snap    = keys;
        m_fixed = cmd[2];
        sio.stb = 1'b0;
        wait_clk(H);
        send_byte(cmd);
        key_in = $urandom;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 8; i++) begin
                sio.dio_in = 1'b1;
                sio.sclk   = 1'b0;
                wait_clk(H);
                got[i] = sio.dio_out;
                if (i == 0) check("rd_oe", sio.dio_oe, 1'b1);
                sio.sclk = 1'b1;
                wait_clk(H);
            end
            if (k < 4) check("rd_byte", got, snap[8*k +: 8]);
            else       check("rd_pad", got, 8'h00);
        end
        wait_clk(H);
        sio.stb = 1'b1;
        wait_clk(3*H);
        check("rd_oe_off", sio.dio_oe, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_oe"}, sio.dio_oe, 1'b0);
        check({tag, "_do"}, sio.dio_out, 1'b0);
        check({tag, "_ram"}, disp_ram, 128'd0);
        check({tag, "_on"}, disp_on, 1'b0);
        check({tag, "_br"}, brightness, 3'd0);
        check({tag, "_ws"}, wr_strobe, 1'b0);
        check({tag, "_wa"}, wr_addr, 4'd0);
        check({tag, "_fe"}, frame_err, 1'b0);
    endtask

    initial begin
        logic [31:0] r;
        rst        = 1'b1;
        sio.stb    = 1'b1;
        sio.sclk   = 1'b1;
        sio.dio_in = 1'b0;
        key_in     = '0;
        m_reset();
        wait_clk(5);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clk(10);

        // Sequential fill with auto-increment.
        do_frame(8'h40);
        for (int a = 0; a < 16; a++) tx.push_back(8'(a));
        do_frame(8'hC0);
        check_state("fill");

        // Fixed address: second byte overwrites the first.
        do_frame(8'h44);
        tx.push_back(8'hAA);
        tx.push_back(8'h55);
        do_frame(8'hC5);
        check_state("fixed");

        do_frame(8'h8F);
        check_state("ctrl_on");
        do_frame(8'h80);
        check_state("ctrl_off");

        do_read(8'h42, 32'h8040_2010);

        // Pointer wraps from 15 to 0.
        do_frame(8'h40);
        tx.push_back(8'h11);
        tx.push_back(8'h22);
        do_frame(8'hCF);
        check_state("wrap");

        // Frame ends three bits into a data byte.
        m_ptr   = 4'd3;
        sio.stb = 1'b0;
        wait_clk(H);
        send_byte(8'hC3);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        wait_clk(H);
        sio.stb = 1'b1;
        wait_clk(3*H);
        ferr_exp++;
        check("partial_ferr", ferr_seen, ferr_exp);
        check_state("partial");

        for (int n = 0; n < 20; n++) begin
            r = $urandom;
            case ($urandom_range(0, 4))
                0: do_frame({5'b01000, r[2], 1'b0, r[0]});
                1: begin
                    for (int j = 0; j < int'($urandom_range(1, 5)); j++)
                        tx.push_back(8'($urandom));
                    do_frame({4'hC, r[3:0]});
                end
                2: begin
                    tx.push_back(8'($urandom));
                    do_frame({2'b10, r[5:0]});
                end
                3: begin
                    tx.push_back(8'($urandom));
                    do_frame({2'b00, r[5:0]});
                end
                default: do_read({2'b01, r[5:3], r[2], 1'b1, r[0]},
                                 $urandom);
            endcase
            check_state("rand");
        end

        // Reset in the middle of a read frame.
        key_in  = 32'hDEAD_BEEF;
        sio.stb = 1'b0;
        wait_clk(H);
        send_byte(8'h42);
        for (int i = 0; i < 5; i++) begin
            sio.sclk = 1'b0;
            wait_clk(H);
            sio.sclk = 1'b1;
            wait_clk(H);
        end
        check("mid_oe_on", sio.dio_oe, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        m_reset();
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        send_byte(8'hC0);
        send_byte(8'hFF);
        wait_clk(H);
        sio.stb = 1'b1;
        wait_clk(3*H);
        check("post_rst_oe", sio.dio_oe, 1'b0);
        check_state("post_rst");

        // Reset restores auto-increment mode.
        tx.push_back(8'h5A);
        tx.push_back(8'hA5);
        tx.push_back(8'h3C);
        do_frame(8'hC0);
        check_state("final");

        check("wr_drained", exp_wr.size(), 0);
        check("ferr_total", ferr_seen, ferr_exp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tm1638_sio_responder.md
# tm1638_sio_responder

Synthesizable TM1638 device-side model: the responder end of the serial link that the TM1638 SIO host driver initiates. It monitors STB/CLK/DIO, decodes data, address and display-control commands, and maintains the 16-byte display RAM and display-control register. On key-read frames it shifts out four key-scan bytes. It is used as a loopback target in simulation and on boards without a TM1638 fitted.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on sclk, stb and dio_in (minimum 2).

Ports:
- clk  in  1  system clock, the single clock of the block.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  serial clock from the host; idles high.
- stb  in  1  frame strobe from the host, active low.
- dio_in  in  1  serial data from the host, LSB first.
- dio_out  out  1  serial data to the host during key reads.
- dio_oe  out  1  output enable for dio_out.
- key_in  in  32  key-scan bytes; byte k = key_in[8k+7:8k].
- disp_ram  out  128  display RAM; address a = disp_ram[8a+7:8a].
- disp_on  out  1  display enable, from control command bit 3.
- brightness  out  3  brightness, from control command bits 2:0.
- wr_strobe  out  1  one-cycle pulse on each RAM byte write.
- wr_addr  out  4  address of the current write; valid with wr_strobe.
- frame_err  out  1  one-cycle pulse when a frame ends on a partial byte.

## Operation
- sclk, stb and dio_in each pass through SYNC_STAGES flops. Rising and falling edges are detected on the synchronized copies, and all decode uses these copies only.
- Sampling: on each synchronized sclk rising edge with stb low, the synchronized dio_in is shifted in LSB-first. A 3-bit counter completes one byte every 8 bits.
- Command decode: the first byte after the stb falling edge is the command.
  - 01xx_xxxx, data command: bit 2 = fixed address (1) / auto-increment (0). This mode is latched and persists across frames. Bit 1 = key read: if set, the state goes to S_RDATA; otherwise to S_IGNORE.
  - 10xx_xxxx, display control: bit 3 is loaded into disp_on and bits 2:0 into brightness. Next state S_IGNORE.
  - 11xx_xxxx, address set: bits 3:0 are loaded into the address pointer. Next state S_WDATA.
  - 00xx_xxxx: ignored. Next state S_IGNORE.
- S_WDATA: each completed byte is written to disp_ram[pointer], and wr_strobe/wr_addr pulse. In auto-increment mode the pointer then increments mod 16, so address 15 wraps to 0. In fixed mode the pointer holds.
- S_RDATA: key_in is snapshotted when the command byte completes.
  - On each synchronized sclk falling edge, dio_out presents the next bit, LSB-first, of byte 0..3.
  - After 4 bytes, dio_out is driven 0 until the frame ends.
  - dio_oe is asserted from the first falling edge after the command until stb rises.
- States: S_IDLE → S_CMD on stb falling edge. S_CMD → S_WDATA, S_RDATA or S_IGNORE on the 8th bit. Any state → S_IDLE on stb rising edge.
- Frame end (stb rising edge):
  - If the bit counter is nonzero, frame_err pulses and the partial byte is discarded (no write).
  - The bit counter clears and dio_oe drops.

## Timing
- Reset values: dio_out 0, dio_oe 0, disp_ram all 0, disp_on 0, brightness 0, wr_strobe 0, wr_addr 0, frame_err 0. Auto-increment mode is selected; pointer is 0; state is S_IDLE.
- Edge detection latency is SYNC_STAGES+1 clk cycles after the pin change.
- A disp_ram write appears, with wr_strobe asserted, 1 cycle after the detected 8th rising edge.
- The dio_out update registers 1 cycle after the detected falling edge.
- The host must hold each sclk half-period at ≥ SYNC_STAGES+4 clk cycles and keep dio_in stable around rising edges for that window.
- A stb rising edge detected in the same cycle as an sclk edge takes priority: the frame ends and the bit is ignored.
- If rst is asserted mid-frame, dio_oe drops immediately (asynchronous). After rst releases, the block resumes only at the next stb falling edge.

## Structure
- tm1638_pkg: command-class constants (CMD_DATA 2'b01, CMD_CTRL 2'b10, CMD_ADDR 2'b11), data-command bit positions (READ bit 1, FIXED bit 2), state enum (S_IDLE, S_CMD, S_WDATA, S_RDATA, S_IGNORE), KEY_BYTES = 4, RAM_BYTES = 16. Shared with the host driver.
- Sub-module tm1638_sync_edge: a parameterized synchronizer plus rise/fall detector, instantiated once for each of sclk, stb and dio_in.

## Test plan
- Write 0x40 frame, then 0xC0 followed by 0x00..0x0F → disp_ram byte a = a, 16 wr_strobe pulses with wr_addr 0..15.
- Write 0x44, then 0xC5 followed by 0xAA, 0x55 → byte 5 = 0x55; every other byte unchanged.
- Write 0x8F → disp_on = 1, brightness = 7. Then write 0x80 → disp_on = 0, brightness = 0. disp_ram is untouched.
- With key_in = 32'h8040_2010, run frame 0x42 plus 4 read bytes → host receives 0x10, 0x20, 0x40, 0x80. dio_oe is high through the read bytes and low after stb rises.
- Write 0x40, then 0xCF followed by 0x11, 0x22 → byte 15 = 0x11, byte 0 = 0x22 (wrap).
- Raise stb after 3 bits of a data byte → no write, one frame_err pulse. Assert rst mid-read → dio_oe = 0 immediately and all outputs at reset values.
